// File: rtl/seq_game_pkg.sv
// Shared definitions for the memory-sequence game: state encoding,
// LFSR taps, datapath widths and the one-hot display helper.
package seq_game_pkg;

  localparam int ELEM_W  = 3;
  localparam int DISP_W  = 8;
  localparam int IDX_W   = 3;
  localparam int TIMER_W = 26;
  localparam int MAX_LEN = 8;

  // Feedback taps for q[7]^q[5]^q[4]^q[3]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GEN   = 3'd1;
  localparam logic [2:0] ST_SHOW  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_INPUT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    GEN   = ST_GEN,
    SHOW  = ST_SHOW,
    GAP   = ST_GAP,
    INPUT = ST_INPUT,
    DONE  = ST_DONE
  } state_t;

  // Converts a stored pattern element into the LED value shown to the user
  function automatic logic [DISP_W-1:0] oneHot(input logic [ELEM_W-1:0] elem);
    return DISP_W'(1) << elem;
  endfunction

endpackage

// File: rtl/sequence_game_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the pattern source.
module lfsr8
  import seq_game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clock,
  input  logic       Resetn,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic       feedback;

  assign feedback = ^(lfsr_q & LFSR_TAPS);

  // Shift every clock; reset reloads the nonzero seed
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], feedback};
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/sequence_game.sv
// Memory-sequence challenge: generates a pseudo-random one-hot pattern,
// plays it back on the LEDs, then checks the user's entries on DataIn.
module sequence_game
  import seq_game_pkg::*;
#(
  parameter int         SEQ_LEN     = 4,
  parameter int         STEP_CYCLES = 50000000,
  parameter int         GAP_CYCLES  = 12500000,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Go,
  input  logic [DISP_W-1:0] DataIn,
  output logic [DISP_W-1:0] Display,
  output logic [3:0]        Progress,
  output logic [3:0]        Mistakes,
  output logic              Mistake,
  output logic              Sequencer
);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(SEQ_LEN - 1);
  localparam logic [TIMER_W-1:0] STEP_LAST = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [ELEM_W-1:0]   pat_q [MAX_LEN];
  logic [DISP_W-1:0]   display_q;
  logic [3:0]          progress_q;
  logic [3:0]          mistakes_q;
  logic                mistake_q;
  logic                sequencer_q;
  logic                go_q;

  logic [7:0]          lfsrVal;
  logic                unusedLfsr;
  logic                press;
  logic [IDX_W-1:0]    idxInc;

  lfsr8 #(.SEED(LFSR_SEED)) uLfsr (
    .Clock  (Clock),
    .Resetn (Resetn),
    .q      (lfsrVal)
  );

  // Only the low bits of the LFSR feed the pattern
  assign unusedLfsr = ^lfsrVal[7:ELEM_W];

  assign press  = Go & ~go_q;
  assign idxInc = idx_q + IDX_W'(1);

  // Delayed copy of Go so a held key registers as a single press
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      go_q <= 1'b0;
    end else begin
      go_q <= Go;
    end
  end

  // Game FSM with pattern store, timer and registered outputs; losing Start aborts from anywhere
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      display_q   <= '0;
      progress_q  <= '0;
      mistakes_q  <= '0;
      mistake_q   <= 1'b0;
      sequencer_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        pat_q[i] <= '0;
      end
    end else begin
      mistake_q <= 1'b0;
      if (state_q != IDLE && !Start) begin
        state_q     <= IDLE;
        idx_q       <= '0;
        timer_q     <= '0;
        display_q   <= '0;
        progress_q  <= '0;
        sequencer_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (Start) begin
              state_q    <= GEN;
              idx_q      <= '0;
              progress_q <= '0;
              mistakes_q <= '0;
            end
          end
          GEN: begin
            pat_q[idx_q] <= lfsrVal[ELEM_W-1:0];
            if (idx_q == LAST_IDX) begin
              idx_q     <= '0;
              timer_q   <= '0;
              display_q <= oneHot(pat_q[0]);
              state_q   <= SHOW;
            end else begin
              idx_q <= idxInc;
            end
          end
          SHOW: begin
            if (timer_q == STEP_LAST) begin
              timer_q   <= '0;
              display_q <= '0;
              state_q   <= GAP;
            end else begin
              timer_q <= timer_q + TIMER_W'(1);
            end
          end
          GAP: begin
            if (timer_q == GAP_LAST) begin
              timer_q <= '0;
              if (idx_q == LAST_IDX) begin
                idx_q   <= '0;
                state_q <= INPUT;
              end else begin
                idx_q     <= idxInc;
                display_q <= oneHot(pat_q[idxInc]);
                state_q   <= SHOW;
              end
            end else begin
              timer_q <= timer_q + TIMER_W'(1);
            end
          end
          INPUT: begin
            if (press) begin
              if (DataIn == oneHot(pat_q[idx_q])) begin
                if (idx_q == LAST_IDX) begin
                  progress_q  <= 4'(SEQ_LEN);
                  sequencer_q <= 1'b1;
                  display_q   <= '1;
                  state_q     <= DONE;
                end else begin
                  idx_q      <= idxInc;
                  progress_q <= progress_q + 4'd1;
                end
              end else begin
                mistake_q  <= 1'b1;
                if (mistakes_q != 4'hF) begin
                  mistakes_q <= mistakes_q + 4'd1;
                end
                progress_q <= '0;
                idx_q      <= '0;
                timer_q    <= '0;
                display_q  <= oneHot(pat_q[0]);
                state_q    <= SHOW;
              end
            end
          end
          DONE: begin
            sequencer_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign Display   = display_q;
  assign Progress  = progress_q;
  assign Mistakes  = mistakes_q;
  assign Mistake   = mistake_q;
  assign Sequencer = sequencer_q;

endmodule

// File: doc/sequence_game.md
Name: sequence_game

Overview:
- Memory-sequence challenge that runs when the alarm controller enters its SEQUENCER state. It consumes the controller's sequencer-start level plus the user's Go key and switches, and returns the Sequencer completion flag that moves the controller to DONE.
- Shows a pseudo-random pattern of one-hot LED values. The user must reproduce it element by element on DataIn and press Go after each one.
- A wrong entry replays the whole pattern from the start.

Parameters:
- SEQ_LEN, 4, number of elements per pattern (legal range 2..8)
- STEP_CYCLES, 50000000, clocks each element is lit during playback (benches override to 4)
- GAP_CYCLES, 12500000, clocks of blank display between elements (benches override to 2)
- LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
- Clock  in  1  system clock, all logic on posedge
- Resetn  in  1  synchronous, active-low reset
- Start  in  1  level from controller; high while in SEQUENCER state
- Go  in  1  active-high user key level, already synchronised; block edge-detects it
- DataIn  in  8  user switch entry
- Display  out  8  one-hot LED pattern during playback, 0 otherwise
- Progress  out  4  count of correct entries in the current attempt
- Mistakes  out  4  wrong entries since Start rose, saturating at 15
- Mistake  out  1  one-cycle pulse on a wrong entry
- Sequencer  out  1  level, high in DONE state

Behaviour:
- Reset (Resetn=0 at posedge):
  - state=IDLE
  - all outputs 0
  - LFSR=LFSR_SEED
  - Go_d=0
  - pattern registers 0
- LFSR: 8-bit Fibonacci, shifts every clock in every state except reset.
  - next = {q[6:0], q[7]^q[5]^q[4]^q[3]}
- Go edge detection: press = Go & ~Go_d, with Go_d registered every cycle. A held Go counts once.
- States: IDLE, GEN, SHOW, GAP, INPUT, DONE.
- IDLE:
  - On Start=1: go to GEN, with idx=0, Mistakes=0, Progress=0.
- GEN (SEQ_LEN cycles):
  - Each cycle, pat[idx] <= LFSR[2:0] and idx++.
  - After the last element: idx=0, timer=0, go to SHOW.
- SHOW:
  - Display = 1<<pat[idx].
  - After STEP_CYCLES clocks, go to GAP with timer reset.
- GAP:
  - Display = 0.
  - After GAP_CYCLES clocks:
    - if idx==SEQ_LEN-1: idx=0, go to INPUT;
    - else: idx++, go to SHOW.
- INPUT:
  - Display = 0.
  - On press, compare all 8 bits: DataIn == 1<<pat[idx].
    - Match, idx != SEQ_LEN-1: idx++, Progress++, stay in INPUT.
    - Match, idx == SEQ_LEN-1: Progress=SEQ_LEN, go to DONE.
    - Mismatch: Mistake=1 for that cycle, Mistakes++ (saturates at 15), Progress=0, idx=0, go to SHOW (replay, same pattern).
  - A press in SHOW, GAP or GEN is ignored; Go_d still updates.
- DONE:
  - Sequencer=1; Display=8'hFF.
  - Stays in DONE while Start=1. On Start=0: go to IDLE, Sequencer=0, Progress=0; Mistakes holds until the next Start.
- Abort: Start=0 in any state other than IDLE goes to IDLE next cycle. This takes priority over every other transition, including a simultaneous correct final press.
- Reset mid-operation: Resetn=0 at any posedge overrides everything and gives the reset values above.
- Timer: 26-bit up-counter, cleared on entry to SHOW/GAP.
- Compare widths: pat elements are 3 bits, idx is 3 bits, shifts are into 8 bits.

Decomposition:
- Shared package seq_game_pkg:
  - state encoding localparams (3-bit)
  - LFSR tap constants
  - ELEM_W=3, DISP_W=8
- One sub-module, lfsr8: ports Clock, Resetn, q[7:0]; parameter SEED.
- Pattern storage, FSM and timer stay in sequence_game.

Test Plan:
- Reset: hold Resetn=0 for 3 clocks with Start=1 -> Display=0, Sequencer=0, Mistakes=0, Progress=0; FSM stays in IDLE until Resetn=1.
- Playback (SEQ_LEN=4, STEP=4, GAP=2, seed A5): raise Start -> after 4 GEN cycles, 4 one-hot values each lit exactly 4 clocks, separated by 2 zero clocks. Values must match the bench LFSR model's bits [2:0] over the 4 GEN cycles.
- Correct entry: after playback, present each observed one-hot value and pulse Go for 1 clock -> Progress steps 1,2,3, then Sequencer=1 and Display=FF on the 4th press; Mistakes=0.
- Wrong entry: second press with DataIn=8'h00 -> Mistake high exactly 1 cycle, Mistakes=1, Progress=0, the same 4-element pattern replays; then correct entries -> Sequencer=1.
- Held Go and early press: hold Go high for 10 clocks in INPUT -> Progress increments only once. Press Go during SHOW -> no change to Progress or Mistakes.
- Abort and saturation: drop Start mid-SHOW -> IDLE next cycle, Display=0. Separately, make 16 wrong entries -> Mistakes stays 15.
